button_event_conditioner: RTL
=============================

// Module: button_event_conditioner
// PURPOSE
//  Multi-channel successor to the single-bit button debouncer. Per channel:
//  2-FF synchroniser, configurable polarity, counter debounce, and one-cycle
//  press, release, long-press and auto-repeat event pulses.
//  Also provides sticky per-channel press flags, readable and clearable from
//  a PIO. Sits between the board buttons/switches and the SOPC PIO inputs.
// PARAMETERS
//  N_CH          3           number of independent input channels
//  ACTIVE_LOW    1           1: pin low = pressed; 0: pin high = pressed
//  DEBOUNCE_CYC  1_000_000   stable cycles before level changes (>=2; 20 ms @ 50 MHz)
//  LONG_CYC      50_000_000  held cycles from press_p to long_p (>=1)
//  REPEAT_CYC    10_000_000  cycles between repeat_p pulses (>=1)
//  Counter widths are localparams: $clog2 of the respective CYC value, minimum 1.
// PORTS
//  clk           in   1     system clock
//  rst_n         in   1     synchronous reset, active low
//  btn_in        in   N_CH  raw asynchronous button pins
//  repeat_en     in   N_CH  per-channel auto-repeat enable
//  clr           in   N_CH  per-channel sticky clear (level, 1 = clear)
//  level         out  N_CH  debounced state, 1 = pressed
//  press_p       out  N_CH  1-cycle pulse on debounced press
//  release_p     out  N_CH  1-cycle pulse on debounced release
//  long_p        out  N_CH  1-cycle pulse when hold reaches LONG_CYC
//  repeat_p      out  N_CH  1-cycle pulse every REPEAT_CYC after long_p
//  event_sticky  out  N_CH  latched press flag
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - all outputs, counters and sync FFs go to 0 (sync FFs to "released"); FSM -> IDLE.
//   - A button held through reset produces a fresh press_p DEBOUNCE_CYC+2 edges after rst_n rises.
//  Sync:
//   - raw_s = 2-FF synchronised btn_in, XOR ACTIVE_LOW.
//  Debounce (per channel):
//   - raw_s==level: cnt<=0.
//   - raw_s!=level: cnt++; when cnt==DEBOUNCE_CYC-1, level<=raw_s and cnt<=0.
//   - A stable pin change shows on level exactly DEBOUNCE_CYC+2 edges later.
//   - Any bounce back restarts the count.
//  Edges:
//   - press_p / release_p are asserted in the first cycle level reads 1 / 0.
//   - Both are registered alongside level.
//  Hold FSM (per channel):
//   - IDLE: on press -> PRESSED, hold_cnt<=0.
//   - PRESSED: hold_cnt++; when hold_cnt==LONG_CYC-1, long_p next cycle, -> HELD, rep_cnt<=0.
//     long_p is therefore LONG_CYC cycles after press_p.
//   - HELD with repeat_en=1: rep_cnt++; when rep_cnt==REPEAT_CYC-1, repeat_p next cycle, rep_cnt<=0.
//   - HELD with repeat_en=0: rep_cnt held at 0 and no repeat_p. Re-enabling restarts a full REPEAT_CYC period.
//   - Release in any state -> IDLE and clears counters.
//   - Release wins: a release in the threshold cycle suppresses long_p / repeat_p.
//  Sticky:
//   - set on press_p; cleared by clr when no press_p is present.
//   - press_p and clr in the same cycle: stays / becomes 1 (set wins).
//  Channels are fully independent; no arbitration. Simultaneous events appear in the same cycle.
//  Outputs are registered; no combinational path from any input to any output.
// TESTING (N_CH=3, ACTIVE_LOW=1, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5)
//  1 ch0 pin toggles every 2 clks for 12 clks, then held low
//    -> level[0] rises exactly 6 edges after the last toggle; exactly one press_p[0]; no pulses earlier.
//  2 ch1 held, repeat_en[1]=1
//    -> long_p[1] 20 clks after press_p[1]; repeat_p[1] at +25,+30,+35;
//    -> on release: release_p[1] and no further pulses.
//  3 ch1 released so level falls in the cycle hold_cnt==19 -> release_p[1]=1 and long_p[1] never asserted.
//  4 ch2 press with clr[2]=1 in the press_p cycle -> event_sticky[2]=1;
//    -> clr[2] pulsed 3 clks later -> event_sticky[2]=0 next cycle.
//  5 rst_n=0 for 1 clk while ch0 in HELD
//    -> all outputs 0 next cycle; pin still low -> press_p[0] 6 edges after rst_n=1.
//  6 all pins driven low on the same edge -> press_p=3'b111 in one cycle; level=3'b111.

Source files
------------

// File: rtl/button_event_conditioner.sv
// Multi-channel button conditioner: 2-FF sync, polarity fix, counter debounce,
// and registered press / release / long-press / auto-repeat pulses plus sticky press flags.
module button_event_conditioner #(
  parameter int N_CH         = 3,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] repeat_p,
  output logic [N_CH-1:0] event_sticky
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam int REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_e;

  // Polarity is folded in before the first flop, so 0 always means released.
  logic [N_CH-1:0] sync_q1;
  logic [N_CH-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_in ^ {N_CH{ACTIVE_LOW}};
      sync_q2 <= sync_q1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic              raw_s;
    logic [DB_W-1:0]   db_cnt;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              sticky_q;
    logic              db_done;
    logic              rise_now;
    logic              fall_now;

    hold_state_e       state_q;
    hold_state_e       state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q;
    logic [REP_W-1:0]  rep_cnt_d;
    logic              long_q;
    logic              long_d;
    logic              repeat_q;
    logic              repeat_d;

    assign raw_s    = sync_q2[ch];
    assign db_done  = (raw_s != level_q) && (db_cnt == DB_LAST);
    assign rise_now = db_done && raw_s;
    assign fall_now = db_done && !raw_s;

    // Debounce counter, level and edge pulses; sticky is set by the press_p already on the output.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        sticky_q  <= 1'b0;
      end else begin
        if ((raw_s == level_q) || db_done) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
        if (db_done) begin
          level_q <= raw_s;
        end
        press_q   <= rise_now;
        release_q <= fall_now;
        sticky_q  <= press_q | (sticky_q & ~clr[ch]);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q    <= IDLE;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
      end
    end

    // A release seen on a threshold edge takes priority, so no late long/repeat pulse escapes.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise_now) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end
        end
        PRESSED: begin
          if (fall_now) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d    = HELD;
            long_d     = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        HELD: begin
          if (fall_now) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else if (!repeat_en[ch]) begin
            rep_cnt_d = '0;
          end else if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      endcase
    end

    assign level[ch]        = level_q;
    assign press_p[ch]      = press_q;
    assign release_p[ch]    = release_q;
    assign long_p[ch]       = long_q;
    assign repeat_p[ch]     = repeat_q;
    assign event_sticky[ch] = sticky_q;
  end

endmodule
